// File: rtl/req_pkg.sv
// Shared definitions for the req_capture83 request-capture block.
package req_pkg;

    localparam int unsigned N        = 8;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned DROP_MAX = 255;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/req_capture83_prio_enc8.sv
// Combinational highest-set-bit encoder: index of the top set bit plus an any-set flag.
module prio_enc8 (
    input  logic [7:0] vec_i,
    output logic [2:0] idx_o,
    output logic       any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Ascending scan so the highest set bit is the last one written.
        for (int unsigned k = 0; k < 8; k++) begin
            if (vec_i[k]) begin
                idx_o = k[2:0];
            end
        end
    end

endmodule

// File: rtl/req_capture83.sv
// Sticky request capture with priority presentation and saturating drop counter.
// Define REQ_CAPTURE83_EDGE_EN for rising-edge events; default build is level-sensitive.
module req_capture83
    import req_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      I,
    input  logic [N-1:0]      mask,
    output logic [CODE_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      pending,
    output logic [7:0]        drop_cnt
);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   out_q, out_d;
    logic                valid_q, valid_d;
    logic [N-1:0]        pend_q, pend_d;
    logic [7:0]          drop_q, drop_d;
    logic [N-1:0]        evt, clr, drops;
    logic [3:0]          drop_num;
    logic [8:0]          drop_sum;
    logic [2:0]          enc_idx;
    logic                enc_any;
    logic                accept;

`ifdef REQ_CAPTURE83_EDGE_EN
    logic [N-1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= I;
        end
    end

    assign evt = I & ~hist_q;
`else
    assign evt = I;
`endif

    prio_enc8 u_enc (
        .vec_i (pend_q & mask),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    assign accept = (state_q == PRESENT) && out_ready;
    assign clr    = accept ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
    // A new event outranks the accept clear on the same line.
    assign pend_d = (pend_q & ~clr) | evt;
    assign drops  = evt & pend_q & ~clr;

    always_comb begin
        drop_num = '0;
        for (int unsigned k = 0; k < N; k++) begin
            drop_num = drop_num + {3'b000, drops[k]};
        end
        drop_sum = {1'b0, drop_q} + {5'b00000, drop_num};
        drop_d   = (drop_sum > 9'(DROP_MAX)) ? 8'(DROP_MAX) : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enc_any) state_d = PRESENT;
            PRESENT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (state_q == IDLE && enc_any) begin
            out_d   = CODE_W'(enc_idx);
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign pending   = pend_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_req_capture83.sv
// Scoreboard bench for req_capture83; compile with or without REQ_CAPTURE83_EDGE_EN.
module tb_req_capture83;

`ifdef REQ_CAPTURE83_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] I = '0;
    logic [7:0] mask = 8'hFF;
    logic       out_ready = 1'b0;
    logic [2:0] out;
    logic       out_valid;
    logic [7:0] pending;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    req_capture83 #(.N(8), .CODE_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .I         (I),
        .mask      (mask),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge+1; at negedge+2 everything the next posedge will see is settled.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL handshake: out=%0d presented, none expected", out);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (out !== 3'(e)) begin
                    n_err++;
                    $display("FAIL handshake: out=%0d expected %0d", out, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        I = '0;
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected indices never presented", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if ({out, out_valid, pending, drop_cnt} !== 20'h0) begin
            n_err++;
            $display("FAIL reset: out=%0d valid=%b pending=%h drop=%0d, all 0 required",
                     out, out_valid, pending, drop_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        mask = 8'hFF; out_ready = 1'b1;
        I = 8'b0000_0100; exp_q.push_back(2);
        tick(); I = '0;
        n_cmp++;
        if (pending !== 8'h04 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latch: pending=%h valid=%b, need 04/0", pending, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd2) begin
            n_err++;
            $display("FAIL single_present: valid=%b out=%0d, need 1/2", out_valid, out);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || pending !== 8'h00) begin
            n_err++;
            $display("FAIL single_accept: valid=%b pending=%h, need 0/00", out_valid, pending);
        end
        check_drained("single");
    endtask

    task automatic test_multi();
        bit exp_v[7] = '{0, 1, 0, 1, 0, 1, 0};
        do_reset();
        mask = 8'hFF; out_ready = 1'b1;
        I = 8'b1001_0001;
        exp_q.push_back(7); exp_q.push_back(4); exp_q.push_back(0);
        tick(); I = '0;
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (out_valid !== exp_v[c]) begin
                n_err++;
                $display("FAIL multi_valid[%0d]: valid=%b expected %b", c, out_valid, exp_v[c]);
            end
            tick();
        end
        n_cmp++;
        if (drop_cnt !== 8'd0 || pending !== 8'h00) begin
            n_err++;
            $display("FAIL multi_end: drop=%0d pending=%h, need 0/00", drop_cnt, pending);
        end
        check_drained("multi");
    endtask

    task automatic test_mask();
        do_reset();
        mask = 8'h7F; out_ready = 1'b1;
        I = 8'b1000_0010; exp_q.push_back(1);
        tick(); I = '0;
        tick(5);
        n_cmp++;
        if (pending !== 8'h80 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mask: pending=%h valid=%b, need 80/0", pending, out_valid);
        end
        check_drained("mask");
        mask = 8'hFF;
    endtask

    task automatic test_hold();
        do_reset();
        mask = 8'hFF; out_ready = 1'b0;
        I = 8'b0000_1000; exp_q.push_back(3);
        tick(); I = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            mask = 8'($urandom);
            if (c == 1) begin
                I = 8'h81; exp_q.push_back(7); exp_q.push_back(0);
            end else begin
                I = '0;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out !== 3'd3) begin
                n_err++;
                $display("FAIL hold[%0d]: valid=%b out=%0d, need 1/3", c, out_valid, out);
            end
            tick();
        end
        mask = 8'hFF; out_ready = 1'b1; I = '0;
        tick();
        n_cmp++;
        if (pending !== 8'h81 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_accept: pending=%h valid=%b, need 81/0", pending, out_valid);
        end
        tick(6);
        check_drained("hold");
    endtask

    task automatic test_set_wins();
        do_reset();
        mask = 8'hFF; out_ready = 1'b0;
        I = 8'b0010_0000; exp_q.push_back(5);
        tick(); I = '0;
        tick();
        out_ready = 1'b1; I = 8'b0010_0000; exp_q.push_back(5);
        tick(); I = '0;
        n_cmp++;
        if (pending !== 8'h20 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL set_wins: pending=%h valid=%b, need 20/0", pending, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd5) begin
            n_err++;
            $display("FAIL set_wins_repr: valid=%b out=%0d, need 1/5", out_valid, out);
        end
        tick();
        n_cmp++;
        if (pending !== 8'h00 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL set_wins_end: pending=%h drop=%0d, need 00/0", pending, drop_cnt);
        end
        check_drained("set_wins");
    endtask

    task automatic test_drop_sat();
        int exp;
        do_reset();
        mask = 8'h00; out_ready = 1'b0;
        I = 8'hFF; tick(); I = '0; tick();
        for (int k = 1; k <= 33; k++) begin
            I = 8'hFF; tick(); I = '0; tick();
            exp = (8 * k > 255) ? 255 : 8 * k;
            if (k == 1 || k == 31 || k == 32 || k == 33) begin
                n_cmp++;
                if (drop_cnt !== 8'(exp) || out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_sat[%0d]: drop=%0d valid=%b, need %0d/0",
                             k, drop_cnt, out_valid, exp);
                end
            end
        end
        mask = 8'hFF;
    endtask

    task automatic test_held();
        int n_pres;
        do_reset();
        mask = 8'hFF; out_ready = 1'b1;
        n_pres = EDGE ? 1 : 4;
        for (int i = 0; i < n_pres; i++) exp_q.push_back(4);
        I = 8'b0001_0000;
        tick(8);
        I = '0;
        tick(4);
        n_cmp++;
        if (drop_cnt !== (EDGE ? 8'd0 : 8'd4) || pending !== 8'h00) begin
            n_err++;
            $display("FAIL held: drop=%0d pending=%h, need %0d/00",
                     drop_cnt, pending, EDGE ? 0 : 4);
        end
        check_drained("held");
    endtask

    task automatic test_reset_mid();
        do_reset();
        mask = 8'hFF; out_ready = 1'b0;
        I = 8'hFF; tick(); I = '0; tick();
        I = 8'hFF; tick(); I = '0; tick();
        I = 8'h03; tick(); I = '0; tick();
        n_cmp++;
        if (pending !== 8'hFF || drop_cnt !== 8'd10 || out_valid !== 1'b1 || out !== 3'd7) begin
            n_err++;
            $display("FAIL mid_setup: pending=%h drop=%0d valid=%b out=%0d, need FF/10/1/7",
                     pending, drop_cnt, out_valid, out);
        end
        I = 8'h01;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out, out_valid, pending, drop_cnt} !== 20'h0) begin
            n_err++;
            $display("FAIL mid_async: out=%0d valid=%b pending=%h drop=%0d, all 0 required",
                     out, out_valid, pending, drop_cnt);
        end
        mask = 8'h00;
        tick();
        rst = 1'b0;
        tick(4);
        n_cmp++;
        if (pending !== 8'h01 || drop_cnt !== (EDGE ? 8'd0 : 8'd3)) begin
            n_err++;
            $display("FAIL mid_held: pending=%h drop=%0d, need 01/%0d",
                     pending, drop_cnt, EDGE ? 0 : 3);
        end
        I = '0; mask = 8'hFF;
        check_drained("reset_mid");
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_multi();
        test_mask();
        test_hold();
        test_set_wins();
        test_drop_sat();
        test_held();
        test_reset_mid();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/req_capture83.md
REQ_CAPTURE83 -- requirements
Module: req_capture83

Interface
REQ-001 Parameter: N, default 8, number of request lines (fixed at 8 for this release).
REQ-002 Parameter: CODE_W, default 3, width of the encoded index.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: I  input  8  raw request lines, bit 7 highest priority.
REQ-006 Port: mask  input  8  per-line enable; 1 = eligible for selection.
REQ-007 Port: out  output  3  encoded index of the presented request.
REQ-008 Port: out_valid  output  1  out holds a valid, unaccepted index.
REQ-009 Port: out_ready  input  1  consumer accepts out when out_valid && out_ready.
REQ-010 Port: pending  output  8  sticky pending-request register.
REQ-011 Port: drop_cnt  output  8  count of requests lost to an already-pending line, saturating.

Function
REQ-012 An event on line k sets pending[k] on the next edge; the event definition is given in Configuration.
REQ-013 pending[k] stays set until its index is accepted on the handshake.
REQ-014 The FSM has two states: IDLE and PRESENT.
REQ-015 IDLE: when (pending & mask) is nonzero, register the index of its highest set bit into out, assert out_valid, and go to PRESENT; otherwise stay in IDLE.
REQ-016 IDLE selection uses the registered pending value, so an event is presented no earlier than 2 edges after it occurs.
REQ-017 PRESENT: out and out_valid hold stable until out_valid && out_ready.
REQ-018 PRESENT: while waiting, changes to mask or pending do not alter out.
REQ-019 Accept edge: clear pending[out], deassert out_valid, and return to IDLE, giving a maximum throughput of 1 index per 2 cycles.
REQ-020 An event on line k in the same cycle that pending[k] is cleared by accept leaves pending[k] set (set wins).
REQ-021 An event on line k while pending[k] is already 1, and not being cleared, increments drop_cnt.
REQ-022 drop_cnt saturates at 255.
REQ-023 Multiple drops in one cycle add their count to drop_cnt, with saturation.
REQ-024 Masked lines still latch into pending and still count drops; they are simply never selected.
REQ-025 out_ready is ignored while out_valid is 0.

Reset
REQ-026 Asserting rst asynchronously forces state=IDLE, out=0, out_valid=0, pending=0, drop_cnt=0, and clears the edge-detect history.
REQ-027 Reset mid-PRESENT discards the presented index; no accept is implied.
REQ-028 The first event can be captured on the first edge after rst deasserts.

Configuration
REQ-029 The macro REQ_CAPTURE83_EDGE_EN selects the event definition.
REQ-030 With REQ_CAPTURE83_EDGE_EN defined, an event is a rising edge on I[k] (I[k]=1 with previous-cycle I[k]=0), held in an 8-bit history register.
REQ-031 With REQ_CAPTURE83_EDGE_EN defined, a line held high produces exactly one event.
REQ-032 With REQ_CAPTURE83_EDGE_EN undefined, an event is I[k]=1 in any cycle, i.e. level-sensitive.
REQ-033 With REQ_CAPTURE83_EDGE_EN undefined, a line held high re-pends immediately after accept and counts a drop every cycle it stays high while pending.

Structure
REQ-034 Shared package req_pkg holds: N, CODE_W, DROP_MAX=255, and the FSM state enum {IDLE, PRESENT}.
REQ-035 The highest-set-bit encode is the sub-module prio_enc8 (8-bit input, 3-bit index, any_valid flag); it is purely combinational and instantiated once.

Verification
REQ-036 Reset, then pulse I=8'b00000100 for 1 cycle with mask=8'hFF and out_ready=1 -> out=2, out_valid for 1 cycle, pending returns to 0.
REQ-037 Set I=8'b10010001 in one cycle with out_ready=1 -> out sequence 7, 4, 0 with 1 idle cycle between each, and drop_cnt=0.
REQ-038 With mask=8'h7F, pulse I=8'b10000010 -> only out=1 is presented, and pending stays 8'b10000000.
REQ-039 Hold out_ready=0 for 5 cycles while presenting 3, and change mask -> out stays 3 and out_valid stays 1; accept then clears pending[3].
REQ-040 Pulse I[5] on the accept edge of index 5 -> pending[5] stays 1, and 5 is presented again.
REQ-041 Assert rst mid-PRESENT with pending=8'hFF and drop_cnt=10 -> all outputs are 0 immediately; run in both macro settings, with a held-high line giving drop_cnt=0 (edge) versus incrementing (level).
